// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, scan FSM encoding and width helper for the 7-segment scan driver
package seg_pkg;
    localparam int NIB_W = 4;
    localparam logic [7:0] ANODE_OFF = '1;
    typedef enum logic {GUARD, ON} scan_state_e;
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: per-slot cycle counter, scanned digit index, guard/on phase and slot-start flag
//   clk, rst     : clock, synchronous active-high reset
//   idx_o        : digit currently being scanned
//   in_guard_o   : high during the all-anodes-off window at the start of a slot
//   tick_o       : high while the slot counter is 0
module seg_slot_timer import seg_pkg::*; #(
    parameter int DIGITS = 4,
    parameter int SLOT_CYC = 50000,
    parameter int GUARD_CYC = 64,
    localparam int IW = clog2(DIGITS),
    localparam int CW = clog2(SLOT_CYC)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx_o,
    output logic          in_guard_o,
    output logic          tick_o
);
    localparam logic [CW-1:0] LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] GC = CW'(GUARD_CYC);
    localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    scan_state_e   state_q;
    // Explicit end-of-range compares so non-power-of-2 sizes wrap correctly.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        idx_d = (cnt_q != LAST) ? idx_q : (idx_q == ILAST) ? '0 : idx_q + IW'(1);
    end
    // Without a guard window the phase never leaves ON.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= (GUARD_CYC == 0) ? ON : GUARD;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= (cnt_d == '0 && GUARD_CYC != 0) ? GUARD : (cnt_d == GC) ? ON : state_q;
        end
    end
    assign idx_o = idx_q;
    assign in_guard_o = (state_q == GUARD);
    assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode 7-segment scan controller
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : one-cycle strobe latching value_i and dp_in_i
//   value_i       : BCD digits, digit 0 in [3:0]
//   dp_in_i       : decimal-point request per digit
//   bcd_o         : nibble of the scanned digit, to the segment mapper
//   anode_o       : active-low digit enables, at most one low
//   dp_o          : decimal point of the scanned digit
//   slot_tick_o   : pulse on the first cycle of every slot
module seg_scan_driver import seg_pkg::*; #(
    parameter int DIGITS = 4,
    parameter int SLOT_CYC = 50000,
    parameter int GUARD_CYC = 64,
    parameter int BLANK_LZ = 1,
    localparam int IW = clog2(DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [NIB_W*DIGITS-1:0] value_i,
    input  logic [DIGITS-1:0]       dp_in_i,
    output logic [NIB_W-1:0]        bcd_o,
    output logic [DIGITS-1:0]       anode_o,
    output logic                    dp_o,
    output logic                    slot_tick_o
);
    logic [NIB_W*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]       dpr_q;
    logic [IW-1:0]           idx;
    logic                    in_guard, tick;
    logic [DIGITS-1:0]       lit;
    logic                    nz, show;
    logic [DIGITS-1:0]       anode_q, anode_d;
    logic [NIB_W-1:0]        bcd_q, bcd_d;
    logic                    dp_q, dp_d, tick_q;
    seg_slot_timer #(
        .DIGITS(DIGITS),
        .SLOT_CYC(SLOT_CYC),
        .GUARD_CYC(GUARD_CYC)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .idx_o(idx),
        .in_guard_o(in_guard),
        .tick_o(tick)
    );
    // nz accumulates from the most significant digit down: a digit stays lit once
    // it or any higher digit carries a nonzero nibble or a decimal point.
    always_comb begin
        nz = 1'b0;
        lit = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz = nz | (val_q[NIB_W*i +: NIB_W] != '0) | dpr_q[i];
            lit[i] = nz | (i == 0) | (BLANK_LZ == 0);
        end
        show = !in_guard && lit[idx];
        bcd_d = val_q[{idx, 2'b00} +: NIB_W];
        anode_d = show ? ~(DIGITS'(1) << idx) : ANODE_OFF[DIGITS-1:0];
        dp_d = show && dpr_q[idx];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '0;
            dpr_q   <= '0;
            anode_q <= ANODE_OFF[DIGITS-1:0];
            bcd_q   <= '0;
            dp_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            if (load_i) begin
                val_q <= value_i;
                dpr_q <= dp_in_i;
            end
            anode_q <= anode_d;
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            tick_q  <= tick;
        end
    end
    assign bcd_o = bcd_q;
    assign anode_o = anode_q;
    assign dp_o = dp_q;
    assign slot_tick_o = tick_q;
endmodule
